// File: rtl/result_uart_tx.sv
// result_uart_tx: serialises each inference result over UART 8N1, MSB byte first.
// Optional macro RESULT_TX_CHECKSUM_EN appends an XOR checksum byte per frame.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resValid,
  input  logic [8*NUM_BYTES-1:0] resData,
  output logic                   txd,
  output logic                   busy,
  output logic                   txStart,
  output logic                   txDone,
  output logic [7:0]             dropCnt
);

`ifdef RESULT_TX_CHECKSUM_EN
  localparam int TOT = NUM_BYTES + 1;
`else
  localparam int TOT = NUM_BYTES;
`endif
  localparam int BW = 8 * TOT;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(TOT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(TOT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [IW-1:0] byte_idx, byte_nx;
  logic [BW-1:0] shreg, shreg_nx;
  logic [BW-1:0] load;
  logic [7:0]    cur;
  logic [7:0]    drop_nx;
  logic          txd_nx, busy_nx, start_nx, done_nx;
  logic          wrap, last, accept;

  assign wrap   = (cnt == CNT_MAX);
  assign last   = (byte_idx == IDX_MAX);
  assign accept = (state == IDLE) && resValid;
  assign cur    = shreg[BW-1 -: 8];

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of all result bytes, loaded as the trailing byte
  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_BYTES; i++)
      csum = csum ^ resData[8*i +: 8];
  end

  assign load = {resData, csum};
`else
  assign load = resData;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: advance only when the baud counter wraps
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (resValid) state_nx = START;
      START:   if (wrap) state_nx = DATA;
      DATA:    if (wrap && bit_idx == 3'd7) state_nx = STOP;
      STOP:    if (wrap) state_nx = last ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of counters, shift buffer and registered outputs
  always_comb begin
    cnt_nx   = (state == IDLE || wrap) ? '0 : cnt + CW'(1);
    bit_nx   = (state == DATA && wrap) ? bit_idx + 3'd1 : bit_idx;
    byte_nx  = byte_idx;
    shreg_nx = shreg;
    if (accept) shreg_nx = load;
    if (state == STOP && wrap) begin
      byte_nx  = last ? '0 : byte_idx + IW'(1);
      shreg_nx = shreg << 8;
    end
    txd_nx = 1'b1;
    if (state_nx == START)     txd_nx = 1'b0;
    else if (state_nx == DATA) txd_nx = cur[bit_nx];
    busy_nx  = (state_nx != IDLE);
    start_nx = accept;
    done_nx  = (state == STOP) && wrap && last;
    drop_nx  = dropCnt;
    if (resValid && state != IDLE && dropCnt != 8'hFF)
      drop_nx = dropCnt + 8'd1;
  end

  // Datapath and output registers; reset aborts any frame with txd high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      txStart  <= 1'b0;
      txDone   <= 1'b0;
      dropCnt  <= '0;
    end else begin
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      shreg    <= shreg_nx;
      txd      <= txd_nx;
      busy     <= busy_nx;
      txStart  <= start_nx;
      txDone   <= done_nx;
      dropCnt  <= drop_nx;
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed vectors for result_uart_tx with CLKS_PER_BIT=4.
// Honours RESULT_TX_CHECKSUM_EN to expect the trailing checksum byte.
module tb_result_uart_tx;

  localparam int C  = 4;
  localparam int NB = 3;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NT = NB + 1;
`else
  localparam int NT = NB;
`endif
  localparam int FRAME = NT * 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resValid = 1'b0;
  logic [23:0] resData = '0;
  logic        txd, busy, txStart, txDone;
  logic [7:0]  dropCnt;

  result_uart_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
    .clk(clk),
    .rst(rst),
    .resValid(resValid),
    .resData(resData),
    .txd(txd),
    .busy(busy),
    .txStart(txStart),
    .txDone(txDone),
    .dropCnt(dropCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [31:0] exp;
  } vec_t;

  int   vecs = 0;
  int   errs = 0;
  int   done_at;
  logic line [512];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    chk("pre_accept_txd", txd, 1);
    resValid = 1'b1;
    resData  = d;
    tick();
    resValid = 1'b0;
    resData  = $urandom;
    chk("start_pulse", txStart, 1);
    chk("start_busy", busy, 1);
    chk("start_txd_low", txd, 0);
  endtask

  task automatic capture(input int inj_at, input logic [23:0] inj,
                         input bit chain, input logic [23:0] cdata);
    logic extra = 1'b0;
    done_at = -1;
    for (int i = 0; i < FRAME + 20 && done_at < 0; i++) begin
      line[i] = txd;
      if (i > 0 && txStart) extra = 1'b1;
      if (txDone) begin
        done_at = i;
        chk("done_busy_low", busy, 0);
        if (chain) begin
          resValid = 1'b1;
          resData  = cdata;
        end
      end
      if (i == inj_at) begin
        resValid = 1'b1;
        resData  = inj;
      end
      tick();
      resValid = 1'b0;
    end
    chk("done_time", done_at, FRAME);
    chk("extra_start", extra, 0);
  endtask

  task automatic decode(input logic [31:0] exp, input string tag);
    logic [7:0] b;
    for (int j = 0; j < NT; j++) begin
      for (int k = 0; k < 8; k++)
        b[k] = line[j*10*C + (k+1)*C + C/2];
      chk({tag, "_startbit"}, line[j*10*C + C/2], 0);
      chk({tag, "_byte"}, b, exp[31-8*j -: 8]);
      chk({tag, "_stopbit"}, line[j*10*C + 9*C + C/2], 1);
    end
  endtask

  task automatic idle_chk(input int n, input string tag);
    logic bad = 1'b0;
    repeat (n) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || txStart !== 1'b0 ||
          txDone !== 1'b0)
        bad = 1'b1;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [5];
    int   aborts [2];
    tbl[0] = '{24'hAABBCC, 32'hAABBCCDD};
    tbl[1] = '{24'h010203, 32'h01020300};
    tbl[2] = '{24'hFF0080, 32'hFF00807F};
    tbl[3] = '{24'h5A3C81, 32'h5A3C81E7};
    tbl[4] = '{24'h800001, 32'h80000181};
    aborts[0] = 37;
    aborts[1] = 2;

    #12;
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_start", txStart, 0);
    chk("reset_done", txDone, 0);
    chk("reset_drop", dropCnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_chk(20, "idle20");
    chk("idle_drop", dropCnt, 0);

    for (int v = 0; v < 5; v++) begin
      send(tbl[v].data);
      capture(-1, '0, 1'b0, '0);
      decode(tbl[v].exp, "vec");
      idle_chk(3, "vec_gap");
    end
    chk("table_drop", dropCnt, 0);

    send(24'hAABBCC);
    capture(50, 24'h112233, 1'b0, '0);
    decode(32'hAABBCCDD, "drop");
    chk("drop_one", dropCnt, 1);
    idle_chk(20, "no_second_frame");

    resValid = 1'b1;
    resData  = 24'h123456;
    repeat (300) tick();
    resValid = 1'b0;
    for (int i = 0; i < FRAME + 10 && busy; i++) tick();
    chk("sat_idle", busy, 0);
    chk("drop_sat", dropCnt, 8'hFF);
    idle_chk(3, "sat_gap");

    send(24'hAABBCC);
    capture(-1, '0, 1'b1, 24'h151515);
    resData = $urandom;
    decode(32'hAABBCCDD, "chain1");
    chk("chain_start", txStart, 1);
    chk("chain_txd", txd, 0);
    capture(-1, '0, 1'b0, '0);
    decode(32'h15151515, "chain2");
    idle_chk(3, "chain_gap");

    for (int a = 0; a < 2; a++) begin
      send(24'h3C0F81);
      repeat (aborts[a]) tick();
      #2;
      rst = 1'b0;
      #1;
      chk("abort_txd", txd, 1);
      chk("abort_busy", busy, 0);
      chk("abort_drop", dropCnt, 0);
      tick();
      tick();
      rst = 1'b1;
      idle_chk(2 * FRAME, "abort_no_done");
    end

    send(24'h010203);
    capture(-1, '0, 1'b0, '0);
    decode(32'h01020300, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
